// File: rtl/mdu_defs_pkg.sv
// mdu_defs: shared encodings and default latencies for the multiply/divide
// sequencing controller and its latency counter.
package mdu_defs;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_COMMIT = 2'd3
    } state_e;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    localparam int DEF_MULT_LAT = 32;
    localparam int DEF_DIV_LAT  = 32;
    localparam int DEF_CNT_W    = 6;

endpackage

// File: rtl/mdu_lat_counter.sv
// mdu_lat_counter: loadable down-counter with a zero flag; it parks at zero
// instead of wrapping, so an extra decrement request is harmless.
module mdu_lat_counter #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: launches the iterative multiply/divide engines, waits out their latency
// and commits Hi/Lo. Define MDU_ENGINE_DONE_EN to wait on engine done pulses instead.
module mdu_ctrl
    import mdu_defs::*;
#(
    parameter int MULT_LAT = DEF_MULT_LAT,
    parameter int DIV_LAT  = DEF_DIV_LAT,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_start,
    input  logic        op_sel,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wr_data,
    output logic [31:0] eng_a,
    output logic [31:0] eng_b,
    output logic        mult_start,
    output logic        div_start,
    input  logic [31:0] mult_hi,
    input  logic [31:0] mult_lo,
    input  logic [31:0] div_hi,
    input  logic [31:0] div_lo,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out,
    output logic        busy,
    output logic        done,
`ifdef MDU_ENGINE_DONE_EN
    input  logic        mult_done,
    input  logic        div_done,
    output logic        timeout,
`endif
    output logic        div_zero
);

    // With engine done pulses the counter becomes a 2*LAT watchdog.
`ifdef MDU_ENGINE_DONE_EN
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(2 * MULT_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(2 * DIV_LAT - 1);
`else
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_LAT - 1);
`endif

    state_e      state_q, state_d;
    logic        sel_q, sel_d;
    logic [31:0] eng_a_q, eng_a_d;
    logic [31:0] eng_b_q, eng_b_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        mult_start_q, mult_start_d;
    logic        div_start_q, div_start_d;
    logic        done_q, done_d;
    logic        div_zero_q, div_zero_d;
    logic        timeout_q, timeout_d;

    logic             cnt_load;
    logic             cnt_dec;
    logic [CNT_W-1:0] cnt_load_val;
    logic             cnt_zero;
    logic             div_by_zero;
    logic             eng_done;

    assign div_by_zero = (op_sel == OP_DIV) && (op_b == 32'd0);

`ifdef MDU_ENGINE_DONE_EN
    assign eng_done = (sel_q == OP_DIV) ? div_done : mult_done;
`else
    assign eng_done = 1'b0;
`endif

    mdu_lat_counter #(
        .CNT_W (CNT_W)
    ) u_lat_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (cnt_load_val),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (op_start && !div_by_zero) begin
                    state_d = ST_LAUNCH;
                end
            end
            ST_LAUNCH: state_d = ST_WAIT;
            ST_WAIT: begin
`ifdef MDU_ENGINE_DONE_EN
                if (eng_done) begin
                    state_d = ST_COMMIT;
                end else if (cnt_zero) begin
                    state_d = ST_IDLE;
                end
`else
                if (cnt_zero) begin
                    state_d = ST_COMMIT;
                end
`endif
            end
            ST_COMMIT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Output/next-value logic; every output is the registered copy of these.
    always_comb begin
        sel_d        = sel_q;
        eng_a_d      = eng_a_q;
        eng_b_d      = eng_b_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        mult_start_d = 1'b0;
        div_start_d  = 1'b0;
        done_d       = 1'b0;
        div_zero_d   = 1'b0;
        timeout_d    = 1'b0;
        cnt_load     = 1'b0;
        cnt_dec      = 1'b0;
        cnt_load_val = (sel_q == OP_DIV) ? DIV_LOAD : MULT_LOAD;
        case (state_q)
            ST_IDLE: begin
                if (hi_we) hi_d = wr_data;
                if (lo_we) lo_d = wr_data;
                if (op_start) begin
                    sel_d   = op_sel;
                    eng_a_d = op_a;
                    eng_b_d = op_b;
                    if (div_by_zero) begin
                        div_zero_d = 1'b1;
                        done_d     = 1'b1;
                    end else begin
                        mult_start_d = (op_sel == OP_MULT);
                        div_start_d  = (op_sel == OP_DIV);
                    end
                end
            end
            ST_LAUNCH: begin
                cnt_load = 1'b1;
            end
            ST_WAIT: begin
                cnt_dec = 1'b1;
                if (!eng_done && cnt_zero) begin
`ifdef MDU_ENGINE_DONE_EN
                    timeout_d = 1'b1;
                    done_d    = 1'b1;
`endif
                end
            end
            ST_COMMIT: begin
                hi_d   = (sel_q == OP_DIV) ? div_hi : mult_hi;
                lo_d   = (sel_q == OP_DIV) ? div_lo : mult_lo;
                done_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sel_q        <= OP_MULT;
            eng_a_q      <= '0;
            eng_b_q      <= '0;
            hi_q         <= '0;
            lo_q         <= '0;
            mult_start_q <= 1'b0;
            div_start_q  <= 1'b0;
            done_q       <= 1'b0;
            div_zero_q   <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            sel_q        <= sel_d;
            eng_a_q      <= eng_a_d;
            eng_b_q      <= eng_b_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
            mult_start_q <= mult_start_d;
            div_start_q  <= div_start_d;
            done_q       <= done_d;
            div_zero_q   <= div_zero_d;
            timeout_q    <= timeout_d;
        end
    end

    assign eng_a      = eng_a_q;
    assign eng_b      = eng_b_q;
    assign hi_out     = hi_q;
    assign lo_out     = lo_q;
    assign mult_start = mult_start_q;
    assign div_start  = div_start_q;
    assign busy       = (state_q != ST_IDLE);
    assign done       = done_q;
    assign div_zero   = div_zero_q;
`ifdef MDU_ENGINE_DONE_EN
    assign timeout    = timeout_q;
`else
    logic unused_timeout;
    assign unused_timeout = timeout_q ^ eng_done;
`endif

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: self-checking bench for mdu_ctrl with behavioural multiply/divide
// engines and a transaction-level HI/LO reference model.
module tb_mdu_ctrl;
    localparam int MLAT = 32;
    localparam int DLAT = 20;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        op_start = 1'b0, op_sel = 1'b0, hi_we = 1'b0, lo_we = 1'b0;
    logic [31:0] op_a = '0, op_b = '0, wr_data = '0;
    logic [31:0] eng_a, eng_b, mult_hi, mult_lo, div_hi, div_lo, hi_out, lo_out;
    logic        mult_start, div_start, busy, done, div_zero;
`ifdef MDU_ENGINE_DONE_EN
    logic        mult_done, div_done, timeout;
`endif
    bit          withhold = 1'b0;

    int total = 0;
    int bad = 0;
    logic [31:0] exp_hi = '0, exp_lo = '0;

    always #5 clk = ~clk;

    mdu_ctrl #(.MULT_LAT(MLAT), .DIV_LAT(DLAT), .CNT_W(6)) dut (
        .clk(clk), .reset(reset), .op_start(op_start), .op_sel(op_sel),
        .op_a(op_a), .op_b(op_b), .hi_we(hi_we), .lo_we(lo_we), .wr_data(wr_data),
        .eng_a(eng_a), .eng_b(eng_b), .mult_start(mult_start), .div_start(div_start),
        .mult_hi(mult_hi), .mult_lo(mult_lo), .div_hi(div_hi), .div_lo(div_lo),
        .hi_out(hi_out), .lo_out(lo_out), .busy(busy), .done(done),
`ifdef MDU_ENGINE_DONE_EN
        .mult_done(mult_done), .div_done(div_done), .timeout(timeout),
`endif
        .div_zero(div_zero)
    );

    function automatic logic [63:0] mul_ref(input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return 64'(sa * sb);
    endfunction

    function automatic logic [63:0] div_ref(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q, r;
        q = 32'($signed(a) / $signed(b));
        r = 32'($signed(a) % $signed(b));
        return {r, q};
    endfunction

    // Engines: results become valid LAT cycles after the start pulse, junk before.
    logic [63:0] m_res = '0, d_res = '0;
    int m_cnt = MLAT + 1;
    int d_cnt = DLAT + 1;
    always @(posedge clk) begin
        if (mult_start) begin
            m_res <= mul_ref(eng_a, eng_b);
            m_cnt <= 0;
        end else if (m_cnt <= MLAT) m_cnt <= m_cnt + 1;
        if (div_start && eng_b != 0) begin
            d_res <= div_ref(eng_a, eng_b);
            d_cnt <= 0;
        end else if (d_cnt <= DLAT) d_cnt <= d_cnt + 1;
    end
    assign mult_hi = (m_cnt >= MLAT) ? m_res[63:32] : (m_res[63:32] ^ 32'h5A5A0F0F);
    assign mult_lo = (m_cnt >= MLAT) ? m_res[31:0]  : (m_res[31:0]  ^ 32'hC3C3F00F);
    assign div_hi  = (d_cnt >= DLAT) ? d_res[63:32] : (d_res[63:32] ^ 32'h5A5A0F0F);
    assign div_lo  = (d_cnt >= DLAT) ? d_res[31:0]  : (d_res[31:0]  ^ 32'hC3C3F00F);
`ifdef MDU_ENGINE_DONE_EN
    assign mult_done = (m_cnt == MLAT - 1) && !withhold;
    assign div_done  = (d_cnt == DLAT - 1) && !withhold;
`endif

    task automatic run_op(input logic sel, input logic [31:0] a, input logic [31:0] b,
                          input bit hw, input bit lw, input logic [31:0] wd,
                          input int bound, input bit disturb,
                          output int done_m, output int done_n, output int busy_n,
                          output int ms_n, output int ds_n, output int dz_n, output int to_n);
        done_m = -1; done_n = 0; busy_n = 0; ms_n = 0; ds_n = 0; dz_n = 0; to_n = 0;
        @(negedge clk);
        op_start = 1'b1; op_sel = sel; op_a = a; op_b = b;
        hi_we = hw; lo_we = lw; wr_data = wd;
        @(negedge clk);
        op_start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        for (int m = 0; m <= bound; m++) begin
            if (done === 1'b1) begin
                if (done_m < 0) done_m = m;
                done_n++;
            end
            busy_n += int'(busy === 1'b1);
            ms_n   += int'(mult_start === 1'b1);
            ds_n   += int'(div_start === 1'b1);
            dz_n   += int'(div_zero === 1'b1);
`ifdef MDU_ENGINE_DONE_EN
            to_n   += int'(timeout === 1'b1);
`endif
            if (disturb && m == 10) begin
                op_start = 1'b1; op_sel = ~sel; op_a = 32'h11111111; op_b = 32'h22222222;
                hi_we = 1'b1; lo_we = 1'b1; wr_data = 32'hBAD0BAD0;
            end else begin
                op_start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        op_start = 1'b1; op_sel = 1'b0; op_a = 32'h5; op_b = 32'h6;
        #12;
        total++;
        if ({hi_out, lo_out, eng_a, eng_b} !== 128'd0) begin
            bad++; $display("FAIL reset_data got %h %h %h %h want 0", hi_out, lo_out, eng_a, eng_b);
        end
        total++;
        if ({busy, done, div_zero, mult_start, div_start} !== 5'd0) begin
            bad++; $display("FAIL reset_ctrl got %b want 00000", {busy, done, div_zero, mult_start, div_start});
        end
        op_start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mult;
        int dm, dn, bn, msn, dsn, dzn, ton;
        run_op(1'b0, 32'd7, 32'hFFFFFFFD, 1'b0, 1'b0, '0, MLAT + 6, 1'b0, dm, dn, bn, msn, dsn, dzn, ton);
        exp_hi = 32'hFFFFFFFF; exp_lo = 32'hFFFFFFEB;
        total++; if (dm !== MLAT + 2) begin bad++; $display("FAIL mult_latency got %0d want %0d", dm, MLAT + 2); end
        total++; if (dn !== 1) begin bad++; $display("FAIL mult_done_width got %0d want 1", dn); end
        total++; if (bn !== MLAT + 2) begin bad++; $display("FAIL mult_busy got %0d want %0d", bn, MLAT + 2); end
        total++; if (msn !== 1 || dsn !== 0) begin bad++; $display("FAIL mult_starts got m=%0d d=%0d want 1 0", msn, dsn); end
        total++; if (hi_out !== exp_hi || lo_out !== exp_lo) begin
            bad++; $display("FAIL mult_result got %h_%h want %h_%h", hi_out, lo_out, exp_hi, exp_lo);
        end
        total++; if (eng_a !== 32'd7 || eng_b !== 32'hFFFFFFFD) begin
            bad++; $display("FAIL mult_operands got %h %h want 7 fffffffd", eng_a, eng_b);
        end
    endtask

    task automatic test_div;
        int dm, dn, bn, msn, dsn, dzn, ton;
        run_op(1'b1, 32'd100, 32'd7, 1'b0, 1'b0, '0, DLAT + 6, 1'b0, dm, dn, bn, msn, dsn, dzn, ton);
        exp_hi = 32'd2; exp_lo = 32'd14;
        total++; if (dm !== DLAT + 2) begin bad++; $display("FAIL div_latency got %0d want %0d", dm, DLAT + 2); end
        total++; if (dsn !== 1 || msn !== 0) begin bad++; $display("FAIL div_starts got d=%0d m=%0d want 1 0", dsn, msn); end
        total++; if (hi_out !== exp_hi || lo_out !== exp_lo) begin
            bad++; $display("FAIL div_result got %h_%h want %h_%h", hi_out, lo_out, exp_hi, exp_lo);
        end
    endtask

    task automatic test_div_zero;
        int dm, dn, bn, msn, dsn, dzn, ton;
        run_op(1'b1, 32'd55, 32'd0, 1'b0, 1'b0, '0, 8, 1'b0, dm, dn, bn, msn, dsn, dzn, ton);
        total++; if (dm !== 0 || dn !== 1) begin bad++; $display("FAIL dz_done got at=%0d n=%0d want 0 1", dm, dn); end
        total++; if (dzn !== 1) begin bad++; $display("FAIL dz_pulse got %0d want 1", dzn); end
        total++; if (bn !== 0 || msn !== 0 || dsn !== 0) begin
            bad++; $display("FAIL dz_quiet got busy=%0d ms=%0d ds=%0d want 0 0 0", bn, msn, dsn);
        end
        total++; if (hi_out !== exp_hi || lo_out !== exp_lo) begin
            bad++; $display("FAIL dz_hilo got %h_%h want %h_%h", hi_out, lo_out, exp_hi, exp_lo);
        end
    endtask

    task automatic test_busy_ignore;
        int dm, dn, bn, msn, dsn, dzn, ton;
        run_op(1'b0, 32'h00012345, 32'h00000321, 1'b0, 1'b0, '0, MLAT + 6, 1'b1, dm, dn, bn, msn, dsn, dzn, ton);
        {exp_hi, exp_lo} = mul_ref(32'h00012345, 32'h00000321);
        total++; if (dm !== MLAT + 2 || dn !== 1) begin bad++; $display("FAIL busy_ign_done got at=%0d n=%0d want %0d 1", dm, dn, MLAT + 2); end
        total++; if (msn + dsn !== 1) begin bad++; $display("FAIL busy_ign_starts got %0d want 1", msn + dsn); end
        total++; if (eng_a !== 32'h00012345) begin bad++; $display("FAIL busy_ign_eng got %h want 00012345", eng_a); end
        total++; if (hi_out !== exp_hi || lo_out !== exp_lo) begin
            bad++; $display("FAIL busy_ign_result got %h_%h want %h_%h", hi_out, lo_out, exp_hi, exp_lo);
        end
    endtask

    task automatic test_mid_reset;
        int dn;
        int dm, bn, msn, dsn, dzn, ton;
        @(negedge clk);
        op_start = 1'b1; op_sel = 1'b0; op_a = 32'd9; op_b = 32'd11;
        @(negedge clk);
        op_start = 1'b0;
        repeat (10) @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL midrst_busy got %b want 1", busy); end
        #2 reset = 1'b0;
        #1;
        exp_hi = '0; exp_lo = '0;
        total++; if ({hi_out, lo_out, eng_a, eng_b, busy, done} !== 130'd0) begin
            bad++; $display("FAIL midrst_clear got hi=%h lo=%h busy=%b", hi_out, lo_out, busy);
        end
        @(negedge clk);
        reset = 1'b1;
        dn = 0;
        for (int i = 0; i < MLAT + 10; i++) begin
            @(negedge clk);
            dn += int'(done === 1'b1);
        end
        total++; if (dn !== 0 || hi_out !== 32'd0 || lo_out !== 32'd0) begin
            bad++; $display("FAIL midrst_nocommit got done=%0d hi=%h lo=%h want 0 0 0", dn, hi_out, lo_out);
        end
        run_op(1'b0, 32'd2, 32'd3, 1'b0, 1'b0, '0, MLAT + 6, 1'b0, dm, dn, bn, msn, dsn, dzn, ton);
        exp_hi = 32'd0; exp_lo = 32'd6;
        total++; if (dm !== MLAT + 2 || hi_out !== exp_hi || lo_out !== exp_lo) begin
            bad++; $display("FAIL midrst_fresh got at=%0d %h_%h want %0d %h_%h", dm, hi_out, lo_out, MLAT + 2, exp_hi, exp_lo);
        end
    endtask

    task automatic test_mtx;
        @(negedge clk);
        hi_we = 1'b1; lo_we = 1'b1; wr_data = 32'hDEADBEEF;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
        exp_hi = 32'hDEADBEEF; exp_lo = 32'hDEADBEEF;
        total++; if (hi_out !== exp_hi || lo_out !== exp_lo) begin
            bad++; $display("FAIL mt_both got %h_%h want %h_%h", hi_out, lo_out, exp_hi, exp_lo);
        end
        hi_we = 1'b1; wr_data = 32'h12345678;
        @(negedge clk);
        hi_we = 1'b0;
        exp_hi = 32'h12345678;
        total++; if (hi_out !== exp_hi || lo_out !== exp_lo) begin
            bad++; $display("FAIL mt_hi_only got %h_%h want %h_%h", hi_out, lo_out, exp_hi, exp_lo);
        end
    endtask

    task automatic test_random;
        int dm, dn, bn, msn, dsn, dzn, ton;
        logic sel;
        logic [31:0] a, b, wd;
        bit hw, lw, dz;
        int lat;
        for (int i = 0; i < 10; i++) begin
            sel = 1'($urandom_range(0, 1));
            a = $urandom; b = $urandom;
            if (sel && $urandom_range(0, 3) == 0) b = '0;
            if (a == 32'h80000000) a = 32'd1;
            hw = 1'($urandom_range(0, 1)); lw = 1'($urandom_range(0, 1)); wd = $urandom;
            dz = sel && (b == 32'd0);
            lat = sel ? DLAT : MLAT;
            run_op(sel, a, b, hw, lw, wd, lat + 6, 1'b0, dm, dn, bn, msn, dsn, dzn, ton);
            if (hw) exp_hi = wd;
            if (lw) exp_lo = wd;
            if (!dz) {exp_hi, exp_lo} = sel ? div_ref(a, b) : mul_ref(a, b);
            total++; if (dm !== (dz ? 0 : lat + 2) || dzn !== int'(dz)) begin
                bad++; $display("FAIL rand_timing[%0d] got at=%0d dz=%0d want %0d %0d", i, dm, dzn, dz ? 0 : lat + 2, dz);
            end
            total++; if (hi_out !== exp_hi || lo_out !== exp_lo) begin
                bad++; $display("FAIL rand_result[%0d] sel=%b a=%h b=%h got %h_%h want %h_%h", i, sel, a, b, hi_out, lo_out, exp_hi, exp_lo);
            end
        end
    endtask

`ifdef MDU_ENGINE_DONE_EN
    task automatic test_timeout;
        int dm, dn, bn, msn, dsn, dzn, ton;
        withhold = 1'b1;
        run_op(1'b0, 32'd5, 32'd6, 1'b0, 1'b0, '0, 2 * MLAT + 6, 1'b0, dm, dn, bn, msn, dsn, dzn, ton);
        withhold = 1'b0;
        total++; if (dm !== 2 * MLAT + 1 || ton !== 1) begin
            bad++; $display("FAIL timeout got at=%0d n=%0d want %0d 1", dm, ton, 2 * MLAT + 1);
        end
        total++; if (hi_out !== exp_hi || lo_out !== exp_lo) begin
            bad++; $display("FAIL timeout_hilo got %h_%h want %h_%h", hi_out, lo_out, exp_hi, exp_lo);
        end
    endtask
`endif

    initial begin
        test_reset;
        test_mult;
        test_div;
        test_div_zero;
        test_busy_ignore;
        test_mid_reset;
        test_mtx;
        test_random;
`ifdef MDU_ENGINE_DONE_EN
        test_timeout;
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
endmodule
